// File: rtl/tetris_vga_render_pkg.sv
// Shared definitions for the Tetris VGA renderer.
// Holds the 640x480@60 timing constants, the playfield geometry, the colour
// palette, the packed sync/enable bundle and a small range helper. It is
// imported by the interface, the timing generator and the render top.
package tetris_vga_render_pkg;

  typedef logic [9:0]  cnt_t;    // hcnt/vcnt and all screen coordinates
  typedef logic [4:0]  sub_t;    // sub-cell pixel counter, 0..19
  typedef logic [3:0]  col_t;    // cell column
  typedef logic [7:0]  idx_t;    // grid bit index, 0..199
  typedef logic [11:0] rgb_t;

  localparam int GRID_BITS = 200;
  typedef logic [GRID_BITS-1:0] grid_t;

  // Horizontal timing
  localparam cnt_t H_VIS  = 10'd640;
  localparam cnt_t H_FP   = 10'd16;
  localparam cnt_t H_SYNC = 10'd96;
  localparam cnt_t H_BP   = 10'd48;
  localparam cnt_t H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing
  localparam cnt_t V_VIS  = 10'd480;
  localparam cnt_t V_FP   = 10'd10;
  localparam cnt_t V_SYNC = 10'd2;
  localparam cnt_t V_BP   = 10'd33;
  localparam cnt_t V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam cnt_t HS_FIRST = H_VIS + H_FP;
  localparam cnt_t HS_LAST  = H_VIS + H_FP + H_SYNC - 10'd1;
  localparam cnt_t VS_FIRST = V_VIS + V_FP;
  localparam cnt_t VS_LAST  = V_VIS + V_FP + V_SYNC - 10'd1;

  // Playfield geometry
  localparam cnt_t PF_X0     = 10'd220;
  localparam cnt_t PF_Y0     = 10'd40;
  localparam sub_t CELL      = 5'd20;
  localparam cnt_t PF_W      = 10'd200;  // 10 cells * 20 px
  localparam cnt_t PF_H      = 10'd400;  // 20 cells * 20 px
  localparam cnt_t BORDER    = 10'd4;
  localparam idx_t IDX_TOP   = 8'd199;   // bit index of row 0, column 0
  localparam idx_t ROW_STEP  = 8'd10;    // bit index distance between rows

  // Palette
  localparam rgb_t COL_BLANK   = 12'h000;
  localparam rgb_t COL_ACTIVE  = 12'hFF0;
  localparam rgb_t COL_SETTLED = 12'h0FF;
  localparam rgb_t COL_EMPTY   = 12'h111;
  localparam rgb_t COL_BORDER  = 12'h888;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0};

  function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/tetris_vga_render_if.sv
// Video bundle between the game engine, the renderer and the display.
//   GridS/GridA : settled / active-piece bitmaps (bit 199-10r-c = row r, col c)
//   hsync/vsync : active-low syncs
//   rgb         : {R,G,B} 4 bits each
//   de          : visible-area enable
//   frame_start : one-cycle pulse at visible pixel (0,0)
// master = engine/display side, slave = renderer.
interface tetris_vga_render_if import tetris_vga_render_pkg::*; ();
  grid_t GridS;
  grid_t GridA;
  logic  hsync;
  logic  vsync;
  rgb_t  rgb;
  logic  de;
  logic  frame_start;

  modport master (
    output GridS, GridA,
    input  hsync, vsync, rgb, de, frame_start
  );

  modport slave (
    input  GridS, GridA,
    output hsync, vsync, rgb, de, frame_start
  );
endinterface

// File: rtl/tetris_vga_render_vga_timing.sv
// 640x480@60 raster counters.
// Ports:
//   clk, rst : pixel clock, synchronous active-high reset
//   hcnt_o   : horizontal counter 0..799
//   vcnt_o   : vertical counter 0..524, advances when hcnt wraps
//   sync_o   : unregistered hs/vs/de/fs decoded from the current counters
module vga_timing import tetris_vga_render_pkg::*; (
  input  logic  clk,
  input  logic  rst,
  output cnt_t  hcnt_o,
  output cnt_t  vcnt_o,
  output sync_t sync_o
);

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_TOT - 10'd1) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_TOT - 10'd1) ? '0 : vcnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    sync_o    = SYNC_IDLE;
    sync_o.hs = !in_range(hcnt_q, HS_FIRST, HS_LAST);
    sync_o.vs = !in_range(vcnt_q, VS_FIRST, VS_LAST);
    sync_o.de = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    sync_o.fs = (hcnt_q == '0) && (vcnt_q == '0);
  end

  assign hcnt_o = hcnt_q;
  assign vcnt_o = vcnt_q;

endmodule

// File: rtl/tetris_vga_render.sv
// Tetris playfield renderer on a 640x480@60 raster.
// Ports:
//   clk, rst : pixel clock, synchronous active-high reset
//   vga      : slave side of tetris_vga_render_if (grids in, video out)
// The grids are snapshotted once per frame at (hcnt,vcnt)=(0,480) so a frame
// never mixes two game states. Every output has a fixed 2-cycle latency from
// the counter state it belongs to.
module tetris_vga_render import tetris_vga_render_pkg::*; (
  input logic               clk,
  input logic               rst,
  tetris_vga_render_if.slave vga
);

  cnt_t  hcnt, vcnt;
  sync_t sync_raw;

  vga_timing u_timing (
    .clk    (clk),
    .rst    (rst),
    .hcnt_o (hcnt),
    .vcnt_o (vcnt),
    .sync_o (sync_raw)
  );

  // Frame snapshot, taken at the start of vertical blanking
  grid_t snap_s_q, snap_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_s_q <= '0;
      snap_a_q <= '0;
    end else if (hcnt == '0 && vcnt == V_VIS) begin
      snap_s_q <= vga.GridS;
      snap_a_q <= vga.GridA;
    end
  end

  // Cell tracking without division: hsub/vsub count pixels inside a cell,
  // col counts cells across, and rbase holds the bit index of column 0 of
  // the current row, stepping down by 10 per row. All values describe the
  // pixel currently addressed by hcnt/vcnt. Outside the playfield they run
  // freely and are ignored.
  sub_t hsub_q, hsub_d;
  col_t col_q, col_d;
  sub_t vsub_q, vsub_d;
  idx_t rbase_q, rbase_d;

  always_comb begin
    hsub_d = hsub_q + 5'd1;
    col_d  = col_q;
    if (hcnt == PF_X0 - 10'd1) begin
      hsub_d = '0;
      col_d  = '0;
    end else if (hsub_q == CELL - 5'd1) begin
      hsub_d = '0;
      col_d  = col_q + 4'd1;
    end

    vsub_d  = vsub_q;
    rbase_d = rbase_q;
    if (hcnt == H_TOT - 10'd1) begin
      if (vcnt == PF_Y0 - 10'd1) begin
        vsub_d  = '0;
        rbase_d = IDX_TOP;
      end else if (vsub_q == CELL - 5'd1) begin
        vsub_d  = '0;
        rbase_d = rbase_q - ROW_STEP;
      end else begin
        vsub_d = vsub_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsub_q  <= '0;
      col_q   <= '0;
      vsub_q  <= '0;
      rbase_q <= IDX_TOP;
    end else begin
      hsub_q  <= hsub_d;
      col_q   <= col_d;
      vsub_q  <= vsub_d;
      rbase_q <= rbase_d;
    end
  end

  logic pf_hit, border_hit;
  idx_t cell_idx;

  assign pf_hit     = (hcnt >= PF_X0) && (hcnt < PF_X0 + PF_W) &&
                      (vcnt >= PF_Y0) && (vcnt < PF_Y0 + PF_H);
  assign border_hit = (hcnt >= PF_X0 - BORDER) && (hcnt < PF_X0 + PF_W + BORDER) &&
                      (vcnt >= PF_Y0 - BORDER) && (vcnt < PF_Y0 + PF_H + BORDER);
  assign cell_idx   = rbase_q - {4'b0000, col_q};

  // Stage 1: cell index and region flags
  sync_t sync_p1_q;
  logic  pf_p1_q, border_p1_q;
  idx_t  idx_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p1_q   <= SYNC_IDLE;
      pf_p1_q     <= 1'b0;
      border_p1_q <= 1'b0;
    end else begin
      sync_p1_q   <= sync_raw;
      pf_p1_q     <= pf_hit;
      border_p1_q <= border_hit;
    end
  end

  always_ff @(posedge clk) begin
    idx_p1_q <= cell_idx;
  end

  // Priority: blanking, active piece, settled cell, empty field, border.
  // The bit lookups are only consulted when pf is set, so an out-of-range
  // index outside the playfield never reaches the output.
  function automatic rgb_t pick_colour(logic de, logic pf, logic border,
                                       logic act, logic set);
    if (!de)             return COL_BLANK;
    else if (pf && act)  return COL_ACTIVE;
    else if (pf && set)  return COL_SETTLED;
    else if (pf)         return COL_EMPTY;
    else if (border)     return COL_BORDER;
    else                 return COL_BLANK;
  endfunction

  // Stage 2: bit lookup and colour
  sync_t sync_p2_q;
  rgb_t  rgb_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p2_q <= SYNC_IDLE;
      rgb_p2_q  <= COL_BLANK;
    end else begin
      sync_p2_q <= sync_p1_q;
      rgb_p2_q  <= pick_colour(sync_p1_q.de, pf_p1_q, border_p1_q,
                               snap_a_q[idx_p1_q], snap_s_q[idx_p1_q]);
    end
  end

  assign vga.hsync       = sync_p2_q.hs;
  assign vga.vsync       = sync_p2_q.vs;
  assign vga.de          = sync_p2_q.de;
  assign vga.frame_start = sync_p2_q.fs;
  assign vga.rgb         = rgb_p2_q;

endmodule

// File: doc/tetris_vga_render.md
TETRIS_VGA_RENDER -- requirements
Module: tetris_vga_render

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, pixel clock; one pixel per cycle, 25 MHz nominal.
REQ-002 The block SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL have port `GridS`: input, 200 bits, settled-cell bitmap from the game engine.
REQ-004 The block SHALL have port `GridA`: input, 200 bits, active-piece bitmap from the game engine.
REQ-005 The block SHALL have port `hsync`: output, 1 bit, horizontal sync, active low.
REQ-006 The block SHALL have port `vsync`: output, 1 bit, vertical sync, active low.
REQ-007 The block SHALL have port `rgb`: output, 12 bits, colour as {R[3:0],G[3:0],B[3:0]}.
REQ-008 The block SHALL have port `de`: output, 1 bit, data enable, high in the visible area.
REQ-009 The block SHALL have port `frame_start`: output, 1 bit, one-cycle pulse at visible pixel (0,0).

Function
REQ-010 Timing SHALL be 640x480@60.
- Horizontal: 640 visible, 16 front porch, 96 sync, 48 back porch; 800 total.
- Vertical: 480 visible, 10 front porch, 2 sync, 33 back porch; 525 total.
REQ-011 The counters SHALL behave as follows:
- hcnt counts 0..799 and wraps to 0.
- vcnt increments when hcnt wraps; vcnt wraps 524->0.
REQ-012 Sync and enable SHALL be derived from the counters (counter frame):
- hsync low when hcnt is in 656..751.
- vsync low when vcnt is in 490..491.
- de high when hcnt<640 and vcnt<480.
REQ-013 Grid mapping SHALL be: row r (0=top, 0..19), column c (0=left, 0..9) maps to bit index 199-10r-c of GridS and GridA.
REQ-014 Playfield geometry SHALL be 20x20 px cells, 10x20 cells, origin x=220, y=40, covering x 220..419 and y 40..439.
REQ-015 Cell row and column SHALL come from incremental sub-cell counters (0..19) advanced with hcnt/vcnt; no divider or multiplier is permitted.
REQ-016 Pixel colour SHALL be selected in this priority order:
- blanking: 12'h000
- active bit set: 12'hFF0
- settled bit set: 12'h0FF
- playfield empty: 12'h111
- 4 px border around the playfield (x 216..423, y 36..443, outside the playfield): 12'h888
- otherwise: 12'h000
REQ-017 Frame snapshot: GridS and GridA SHALL be captured into internal registers on the cycle with hcnt==0 and vcnt==480. Rendering SHALL use only the snapshot, so input changes mid-frame never tear.
REQ-018 The pipeline SHALL be 2 stages.
- Stage 1 registers the cell index and region flags.
- Stage 2 registers the bit lookup and colour.
REQ-019 hsync, vsync, de and frame_start SHALL be delayed to match, so all outputs share a fixed 2-cycle latency from the counter state.
REQ-020 frame_start SHALL be high for exactly one cycle per frame, 2 cycles after the counter reaches (0,0).
REQ-021 rgb SHALL be 0 whenever de is 0.

Reset
REQ-022 While rst is high, the block SHALL hold:
- hcnt=0, vcnt=0, sub-cell counters 0
- snapshot=0
- pipeline flags cleared
- hsync=1, vsync=1, rgb=0, de=0, frame_start=0
REQ-023 When rst is asserted mid-frame, the block SHALL abandon the frame and take reset values on the next edge. After release, counting SHALL restart at (0,0). The snapshot SHALL stay 0 (empty playfield drawn) until the first capture at vcnt==480.

Structure
REQ-024 A shared package SHALL hold:
- timing constants: H/V visible, porch and sync widths, totals
- playfield origin, cell size, border width
- the five colour constants
REQ-025 A sub-module `vga_timing` SHALL hold the hcnt/vcnt counters and raw hsync/vsync/de/frame_start generation. Rendering, snapshot and the pipeline SHALL stay in tetris_vga_render.

Verification
REQ-026 Reset then free-run. Required response:
- hsync low for 96 cycles of every 800.
- vsync low for 1600 cycles of every 420000.
- frame_start one pulse per 420000 cycles.
REQ-027 GridS bit199=1, all else 0, held across a capture. Required response in the next frame:
- rgb=12'h0FF for pixels x 220..239, y 40..59.
- rgb=12'h111 at x=240, y=40.
REQ-028 GridS and GridA both with bit 0 set. Required response:
- rgb=12'hFF0 at x 400..419, y 420..439 (active priority).
REQ-029 Toggle GridS at vcnt=200. Required response:
- Current frame unchanged.
- Change visible only after the vcnt==480 capture.
REQ-030 Border and outside pixels. Required response:
- (x=216, y=100): 12'h888
- (x=215, y=100): 12'h000
- hcnt in 640..799: rgb=0, de=0
REQ-031 Assert rst at hcnt=300, vcnt=250 for 3 cycles. Required response:
- Outputs at reset values on the next edge.
- frame_start 2 cycles after release.
- Empty playfield until the first capture.
